score_scan_ctrl: RTL
====================

Name: score_scan_ctrl

Overview:
Score-keeping and display-scan stage for the Pong scoreboard.
- Counts points for the left and right players.
- Detects game over.
- Time-multiplexes the two scores onto the 4-digit 7-segment display.
- Directly feeds the 7-segment digit decoder through its num/sel/en inputs. The decoder turns sel into the anode pattern and num into the segment pattern.

Parameters:
REFRESH_DIV, 100000, clk cycles each digit slot is held (>=2).
WIN_SCORE, 3, score that ends the game (1..3; the downstream decoder renders only 0..3).
BLINK_FRAMES, 50, complete 4-slot scan frames per blink half-period in game-over (>=1).

Ports:
clk  input  1  system clock.
rst  input  1  reset, asynchronous, active-high.
point_left  input  1  one-cycle pulse: left player scored.
point_right  input  1  one-cycle pulse: right player scored.
new_game  input  1  one-cycle pulse: clear scores, restart play.
num  output  3  digit value to decoder.
sel  output  2  digit slot to decoder (0 = rightmost, 3 = leftmost).
en  output  1  display enable to decoder.
game_over  output  1  high while in OVER state.
winner  output  1  0 = left won, 1 = right won; valid while game_over.

Behaviour:
Reset (async assert, sync to clk on release):
- score_l = 0, score_r = 0, prescaler = 0, frame count = 0, state = PLAY.
- Outputs: sel = 0, num = 0, en = 1, game_over = 0, winner = 0.

All outputs are registered.

State machine: PLAY, OVER.
- PLAY, scoring:
  - point_left increments score_l.
  - point_right increments score_r.
  - Both high in the same cycle: both increment.
- PLAY, win detection:
  - If a new score equals WIN_SCORE, go to OVER on the same edge.
  - game_over = 1 from the next cycle.
  - winner = 1 only if score_r reached WIN_SCORE and score_l did not. Simultaneous win: winner = 0 (left).
- OVER:
  - Scores frozen; point pulses ignored.
  - new_game -> PLAY, both scores 0, game_over = 0, winner = 0.
- new_game in PLAY: clears scores and stays in PLAY.
- new_game has priority over any point pulse in the same cycle.
- Scores never exceed WIN_SCORE; width is 2 bits, zero-extended onto num.

Scan:
- Prescaler counts 0..REFRESH_DIV-1 and wraps.
- On the wrap cycle, sel advances 0->1->2->3->0.
- sel is constant for exactly REFRESH_DIV cycles.
- num is updated on the same edge as sel:
  - sel = 0: num = score_r
  - sel = 3: num = score_l
  - sel = 1 or 2: num = 0 (the decoder blanks these slots)
- A score change is reflected on num in the same cycle it appears on the register, when the matching slot is active.
- The scan runs continuously in both states; new_game does not reset the scan.

Blink (OVER only, see Optional Feature):
- Frame = a sel wrap 3->0.
- Every BLINK_FRAMES frames, en toggles.
- On entering OVER: frame count = 0, en = 1.
- On leaving OVER: en = 1.

Optional Feature:
Macro OVER_BLINK_EN.
- Defined: en blinks in OVER as described above.
- Undefined: en is constantly 1; the frame counter and blink logic are not synthesized; the final score stays steady.
- game_over and winner are identical in both builds.

Test Plan:
1. Reset behaviour (REFRESH_DIV = 4): assert rst mid-scan -> outputs immediately sel = 0, num = 0, en = 1, game_over = 0. Release -> sel steps 0,1,2,3,0 with 4 cycles per value.
2. Right scores: one point_right pulse, then point_left twice -> score_r = 1, score_l = 2. num = 1 while sel = 0, num = 2 while sel = 3, num = 0 while sel = 1 or 2.
3. Right wins (WIN_SCORE = 3): three point_right pulses -> game_over = 1 on the cycle after the third pulse, winner = 1. A further point_left leaves score_l unchanged.
4. Simultaneous events: both players at 2, pulse point_left and point_right together -> both scores = 3, game_over = 1, winner = 0. Separately, new_game together with point_left -> scores 0/0, state PLAY.
5. Blink (OVER_BLINK_EN, BLINK_FRAMES = 2, REFRESH_DIV = 4): after game over, en toggles every 32 cycles. new_game -> en = 1 and stays 1. Without the macro, en stays 1 throughout.

Source files
------------

// File: rtl/score_scan_ctrl_if.sv
// score_scan_ctrl_if: point/new-game pulses in, decoder drive and game status out
interface score_scan_ctrl_if;
   logic       point_left;
   logic       point_right;
   logic       new_game;
   logic [2:0] num;
   logic [1:0] sel;
   logic       en;
   logic       game_over;
   logic       winner;
   modport master (output point_left, point_right, new_game, input num, sel, en, game_over, winner);
   modport slave  (input point_left, point_right, new_game, output num, sel, en, game_over, winner);
endinterface

// File: rtl/score_scan_ctrl.sv
// score_scan_ctrl: Pong score keeping, game-over detection and 4-digit display scan.
// Define OVER_BLINK_EN to make the display blink while the game is over.
module score_scan_ctrl #(
   parameter int REFRESH_DIV  = 100000,
   parameter int WIN_SCORE    = 3,
   parameter int BLINK_FRAMES = 50
) (
   input logic             clk,
   input logic             rst,
   score_scan_ctrl_if.slave bus
);
   typedef enum logic {PLAY, OVER} state_t;
   localparam int PW = $clog2(REFRESH_DIV);
   localparam logic [1:0] WIN = 2'(WIN_SCORE);

   state_t          state_q, state_d;
   logic [PW-1:0]   pre_q, pre_d;
   logic [1:0]      sel_q, sel_d, score_l_q, score_l_d, score_r_q, score_r_d, inc_l, inc_r;
   logic [2:0]      num_q, num_d;
   logic            go_q, go_d, win_q, win_d, en_q, en_d, wrap, hit_l, hit_r;

   always_ff @(posedge clk or posedge rst)
      if (rst) state_q <= PLAY;
      else     state_q <= state_d;

   always_comb begin
      inc_l   = score_l_q + 2'(bus.point_left);
      inc_r   = score_r_q + 2'(bus.point_right);
      hit_l   = inc_l == WIN;
      hit_r   = inc_r == WIN;
      state_d = bus.new_game ? PLAY : (state_q == PLAY && (hit_l || hit_r)) ? OVER : state_q;
   end

   always_comb begin
      wrap      = pre_q == PW'(REFRESH_DIV - 1);
      pre_d     = wrap ? '0 : pre_q + PW'(1);
      sel_d     = sel_q + 2'(wrap);
      score_l_d = bus.new_game ? '0 : state_q == PLAY ? inc_l : score_l_q;
      score_r_d = bus.new_game ? '0 : state_q == PLAY ? inc_r : score_r_q;
      // num follows the next-cycle slot and scores so both land on the same edge
      num_d     = sel_d == 2'd0 ? {1'b0, score_r_d} : sel_d == 2'd3 ? {1'b0, score_l_d} : 3'd0;
      go_d      = state_d == OVER;
      win_d     = bus.new_game ? 1'b0 : state_q == PLAY ? (hit_r & ~hit_l) : win_q;
   end

`ifdef OVER_BLINK_EN
   localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
   logic [FW-1:0] fc_q, fc_d;
   logic          frame, last;

   always_comb begin
      frame = wrap && sel_q == 2'd3;
      last  = fc_q == FW'(BLINK_FRAMES - 1);
      fc_d  = state_q != OVER ? '0 : frame ? (last ? '0 : fc_q + FW'(1)) : fc_q;
      en_d  = (state_q != OVER || state_d != OVER) ? 1'b1 : (frame && last) ? ~en_q : en_q;
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) fc_q <= '0;
      else     fc_q <= fc_d;
`else
   assign en_d = 1'b1;
`endif

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         pre_q     <= '0;
         sel_q     <= '0;
         score_l_q <= '0;
         score_r_q <= '0;
         num_q     <= '0;
         go_q      <= 1'b0;
         win_q     <= 1'b0;
         en_q      <= 1'b1;
      end else begin
         pre_q     <= pre_d;
         sel_q     <= sel_d;
         score_l_q <= score_l_d;
         score_r_q <= score_r_d;
         num_q     <= num_d;
         go_q      <= go_d;
         win_q     <= win_d;
         en_q      <= en_d;
      end

   assign bus.num       = num_q;
   assign bus.sel       = sel_q;
   assign bus.en        = en_q;
   assign bus.game_over = go_q;
   assign bus.winner    = win_q;
endmodule
